mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter: W, 16, operand/result width; only W=16 is required and verified.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: op_a  input  16  multiplicand; sampled with start.
REQ-006 SHALL have port: op_b  input  16  multiplier; sampled with start.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: product  output  16  low 16 bits of op_a*op_b.
REQ-010 SHALL have port: ovf  output  1  set when the true product exceeds 0xFFFF.
REQ-011 SHALL have port: alu_ctrl  output  3  opcode to the shared ALU (000 add, 011 shl, 100 shr).
REQ-012 SHALL have ports: alu_a, alu_b  outputs  16 each  ALU operands.
REQ-013 SHALL have ports: alu_result  input  16, alu_zero  input  1  combinational ALU outputs, same cycle.

Function
REQ-014 SHALL use states IDLE, ADD, SHL, SHR, DONE; internal registers P (partial product), M (multiplicand), Q (multiplier), iteration count 0..16.
REQ-015 In IDLE with start=1, SHALL latch M=op_a, Q=op_b, P=0, ovf=0, count=0, and go to ADD.
REQ-016 ADD SHALL drive alu_ctrl=000, alu_a=P, alu_b=(Q[0] ? M : 0), and load P=alu_result; go to SHL.
REQ-017 In ADD, SHALL set ovf if Q[0]=1 and alu_result < P (unsigned wrap).
REQ-018 SHL SHALL drive alu_ctrl=011, alu_a=M, alu_b=1, and load M=alu_result; go to SHR.
REQ-019 In SHL, SHALL set ovf if M[15]=1 and Q[15:1]!=0.
REQ-020 SHR SHALL drive alu_ctrl=100, alu_a=Q, alu_b=1, load Q=alu_result, and increment count.
REQ-021 From SHR, SHALL go to DONE if alu_zero=1 or the incremented count=16; otherwise go to ADD.
REQ-022 ovf SHALL be sticky within an operation, cleared only at start acceptance or reset.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-024 product SHALL equal P at all times and hold its value after DONE until the next accepted start; ovf SHALL behave the same.
REQ-025 Iteration count k SHALL be max(1, index of the highest set bit of op_b + 1).
REQ-026 If start is accepted at cycle 0, done SHALL assert at cycle 3k+1, with busy=1 in cycles 1..3k+1.
REQ-027 start SHALL be ignored while busy=1; no latching, restart or queueing.
REQ-028 In IDLE and DONE, SHALL drive alu_ctrl=000, alu_a=0, alu_b=0.
REQ-029 Start in the same cycle that done is high SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-030 rst=1 SHALL, at the next clock edge, force IDLE and clear P, M, Q, count, ovf, done, and busy, regardless of state.
REQ-031 rst SHALL take priority over start in the same cycle.
REQ-032 After reset, until the next start, all outputs SHALL read 0.

Verification
REQ-033 op_a=3, op_b=5, start at cycle 0 -> k=3; done at cycle 10; product=0x000F; ovf=0.
REQ-034 op_a=0x1234, op_b=0 -> k=1; done at cycle 4; product=0; ovf=0.
REQ-035 op_a=0xFFFF, op_b=0xFFFF -> k=16; done at cycle 49; product=0x0001; ovf=1.
REQ-036 op_a=0x0100, op_b=0x0100 -> done at cycle 28; product=0x0000; ovf=1.
REQ-037 Start op_a=7, op_b=9; pulse start with new operands at cycle 3 -> ignored; done at cycle 13; product=0x003F.
REQ-038 Start op_a=0xFFFF, op_b=0xFFFF; rst=1 at cycle 5 -> cycle 6: busy=0, done=0, product=0, ovf=0; a new start at cycle 7 runs to completion.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential shift-and-add multiplier controller.
// The datapath arithmetic is done by an external shared ALU; this block
// sequences ADD / SHL / SHR steps over the registers P, M, Q and reports the
// low W bits of the product plus an overflow flag.
module mul_seq_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product,
    output logic         ovf,
    output logic [2:0]   alu_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero
);

    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADD  = 3'd1;
    localparam logic [2:0] S_SHL  = 3'd2;
    localparam logic [2:0] S_SHR  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;

    logic [2:0]    state;
    logic [W-1:0]  p_reg;
    logic [W-1:0]  m_reg;
    logic [W-1:0]  q_reg;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          ovf_reg;

    assign count_next = count + CW'(1);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign product    = p_reg;
    assign ovf        = ovf_reg;

    // Drive the shared ALU for the current step; idle states present zeros.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_a    = '0;
        alu_b    = '0;
        case (state)
            S_ADD: begin
                alu_ctrl = ALU_ADD;
                alu_a    = p_reg;
                alu_b    = q_reg[0] ? m_reg : '0;
            end
            S_SHL: begin
                alu_ctrl = ALU_SHL;
                alu_a    = m_reg;
                alu_b    = W'(1);
            end
            S_SHR: begin
                alu_ctrl = ALU_SHR;
                alu_a    = q_reg;
                alu_b    = W'(1);
            end
            default: ;
        endcase
    end

    // Step sequencer and register updates; reset wins over everything.
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            p_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            count   <= '0;
            ovf_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg   <= op_a;
                        q_reg   <= op_b;
                        p_reg   <= '0;
                        ovf_reg <= 1'b0;
                        count   <= '0;
                        state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    p_reg <= alu_result;
                    // Unsigned wrap of the accumulation means bits were lost.
                    if (q_reg[0] && (alu_result < p_reg)) begin
                        ovf_reg <= 1'b1;
                    end
                    state <= S_SHL;
                end
                S_SHL: begin
                    m_reg <= alu_result;
                    // A multiplicand bit is shifted out while higher multiplier
                    // bits still need it: the true product cannot fit.
                    if (m_reg[W-1] && (q_reg[W-1:1] != '0)) begin
                        ovf_reg <= 1'b1;
                    end
                    state <= S_SHR;
                end
                S_SHR: begin
                    q_reg <= alu_result;
                    count <= count_next;
                    if (alu_zero || (count_next == CW'(W))) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for mul_seq_ctrl with a behavioural ALU.
// Stimulus pushes the expected product, overflow and completion cycle of each
// accepted operation; a monitor pops and compares whenever done is seen.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    mul_seq_ctrl #(.W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .ovf        (ovf),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU behaviour: add, shift left, shift right.
    always_comb begin
        alu_result = 16'h0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = alu_a << alu_b;
            3'b100:  alu_result = alu_a >> alu_b;
            default: alu_result = 16'h0;
        endcase
        alu_zero = (alu_result == 16'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iters(input logic [15:0] b);
        int k = 1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) k = i + 1;
        end
        return k;
    endfunction

    // Push the reference result for an operation accepted in cycle c.
    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input int c);
        exp_t e;
        logic [31:0] full;
        full       = {16'h0, a} * {16'h0, b};
        e.prod     = full[15:0];
        e.ovf      = (full > 32'h0000_FFFF);
        e.done_cyc = c + 3 * iters(b) + 1;
        sb.push_back(e);
    endtask

    // Called at a negedge in IDLE: present start for one cycle.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        push_exp(a, b, cyc);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n >= 300), 0);
        if (n >= 300) sb.delete();
        @(negedge clk);
    endtask

    // Monitor: compare on every done pulse and check the held result after it.
    logic        done_prev = 1'b0;
    logic        hold_pend = 1'b0;
    exp_t        last;
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_product", 32'(product), 32'(last.prod));
                check("hold_ovf", 32'(ovf), 32'(last.ovf));
                check("idle_after_done", 32'(busy), 0);
                hold_pend = 1'b0;
            end
            if (done) begin
                check("done_single_cycle", 32'(done_prev), 0);
                check("done_expected", 32'(sb.size() != 0), 1);
                check("busy_in_done", 32'(busy), 1);
                if (sb.size() != 0) begin
                    last = sb.pop_front();
                    check("product", 32'(product), 32'(last.prod));
                    check("ovf", 32'(ovf), 32'(last.ovf));
                    check("done_cycle", 32'(cyc), 32'(last.done_cyc));
                    hold_pend = 1'b1;
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] masks [4];
        int          n;
        masks[0] = 16'h0003;
        masks[1] = 16'h000F;
        masks[2] = 16'h00FF;
        masks[3] = 16'hFFFF;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = 16'h0;
        op_b  = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_product", 32'(product), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);

        // Reset has priority over start.
        start = 1'b1;
        op_a  = 16'h0005;
        op_b  = 16'h0005;
        @(negedge clk);
        check("rst_over_start", 32'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(busy), 0);

        // Directed cases.
        issue(16'h0003, 16'h0005); wait_idle();
        issue(16'h1234, 16'h0000); wait_idle();
        issue(16'hFFFF, 16'hFFFF); wait_idle();
        issue(16'h0100, 16'h0100); wait_idle();

        // Start while busy is ignored.
        issue(16'h0007, 16'h0009);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'hAAAA;
        op_b  = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start during the done cycle is ignored; the next IDLE cycle accepts it.
        issue(16'h0011, 16'h0006);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_timeout", 32'(n >= 100), 0);
        start = 1'b1;
        op_a  = 16'h00FF;
        op_b  = 16'h0003;
        @(negedge clk);
        check("idle_cycle_after_done", 32'(busy), 0);
        op_a = 16'h0123;
        op_b = 16'h0011;
        push_exp(op_a, op_b, cyc);
        @(negedge clk);
        start = 1'b0;
        check("accept_after_done", 32'(busy), 1);
        wait_idle();

        // Reset in the middle of an operation.
        issue(16'hFFFF, 16'hFFFF);
        repeat (4) @(negedge clk);
        check("ovf_before_rst", 32'(ovf), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_product", 32'(product), 0);
        check("midrst_ovf", 32'(ovf), 0);
        @(negedge clk);
        issue(16'h00C3, 16'h0101); wait_idle();

        // Randomized operations with occasional ignored start pulses.
        for (int t = 0; t < 40; t++) begin
            issue(16'($urandom), 16'($urandom) & masks[$urandom_range(0, 3)]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (busy && !done) begin
                start = 1'b1;
                op_a  = 16'($urandom);
                op_b  = 16'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
